// File: rtl/vs_uart_tx_buf.sv
// Buffered UART transmitter: a 1-deep holding register feeds a start/data/parity/stop
// serialiser timed by a 16x oversample tick divider. TXD, TX_BUSY and TX_DONE are registered.
module vs_uart_tx_buf #(
   parameter int DIV        = 868,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       TX_RDY_T,
   input  logic [7:0] TX_DATA_R,
   output logic       TX_RDY_R,
   output logic       TXD,
   output logic       TX_BUSY,
   output logic       TX_DONE
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
   localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

   state_t      state_q;
   logic        hold_full_q, hold_full_d;
   logic [7:0]  hold_data_q, hold_data_d;
   logic [7:0]  shift_q;
   logic        par_q;
   logic [15:0] div_q;
   logic [3:0]  tick_q;
   logic [2:0]  bit_q;
   logic        txd_q, busy_q, done_q, end_q;
   logic        line_d, accept, drain, tick, bit_end, last_stop;

   function automatic logic parity_of(input logic [7:0] b);
      return (^b) ^ (PARITY_ODD != 0);
   endfunction

   always_comb begin
      accept    = TX_RDY_T & ~hold_full_q;
      tick      = (state_q != S_IDLE) && (div_q == DIV_LAST);
      bit_end   = tick && (tick_q == 4'd15);
      last_stop = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);
      drain     = hold_full_q && ((state_q == S_IDLE) || last_stop);
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      if (drain) hold_full_d = 1'b0;
      // A new byte arriving on the drain edge keeps the register full.
      if (accept) begin
         hold_full_d = 1'b1;
         hold_data_d = TX_DATA_R;
      end
      case (state_q)
         S_START:  line_d = 1'b0;
         S_DATA:   line_d = shift_q[0];
         S_PARITY: line_d = par_q;
         default:  line_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         hold_full_q <= 1'b0;
         div_q       <= '0;
         tick_q      <= '0;
         bit_q       <= '0;
         txd_q       <= 1'b1;
         busy_q      <= 1'b0;
         end_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
         txd_q       <= line_d;
         busy_q      <= (state_q != S_IDLE);
         end_q       <= last_stop;
         done_q      <= end_q;

         // Divider parks at zero while idle so each frame starts on a fresh bit period.
         if (state_q == S_IDLE) begin
            div_q  <= '0;
            tick_q <= '0;
         end else if (tick) begin
            div_q  <= '0;
            tick_q <= tick_q + 4'd1;
         end else begin
            div_q  <= div_q + 16'd1;
         end

         case (state_q)
            S_IDLE: begin
               if (hold_full_q) begin
                  shift_q <= hold_data_q;
                  par_q   <= parity_of(hold_data_q);
                  bit_q   <= '0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  bit_q   <= '0;
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  shift_q <= {1'b0, shift_q[7:1]};
                  if (bit_q == 3'd7) begin
                     bit_q   <= '0;
                     state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                  end
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  bit_q   <= '0;
                  state_q <= S_STOP;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  if (bit_q == STOP_LAST) begin
                     bit_q <= '0;
                     if (hold_full_q) begin
                        shift_q <= hold_data_q;
                        par_q   <= parity_of(hold_data_q);
                        state_q <= S_START;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign TX_RDY_R = ~hold_full_q;
   assign TXD      = txd_q;
   assign TX_BUSY  = busy_q;
   assign TX_DONE  = done_q;

endmodule

// File: tb/tb_vs_uart_tx_buf.sv
// Directed bench for vs_uart_tx_buf: four parameterisations share one clock and reset;
// a selector routes the handshake to one instance and its outputs into a sample record.
module tb_vs_uart_tx_buf;

   logic       CLK = 1'b0;
   logic       RST;
   logic       tx_v;
   logic [7:0] tx_d;
   logic [1:0] sel;
   logic [3:0] vld_w, rdy_w, txd_w, busy_w, done_w;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_err = 0;
   int         kref, k2, g;
   logic [31:0] w;

   logic txd_s  [0:1499];
   logic busy_s [0:1499];
   logic done_s [0:1499];
   logic rdy_s  [0:1499];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   assign vld_w = tx_v ? (4'b0001 << sel) : 4'b0000;

   vs_uart_tx_buf #(.DIV(4)) u_a (
      .CLK(CLK), .RST(RST), .TX_RDY_T(vld_w[0]), .TX_DATA_R(tx_d),
      .TX_RDY_R(rdy_w[0]), .TXD(txd_w[0]), .TX_BUSY(busy_w[0]), .TX_DONE(done_w[0]));
   vs_uart_tx_buf #(.DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_b (
      .CLK(CLK), .RST(RST), .TX_RDY_T(vld_w[1]), .TX_DATA_R(tx_d),
      .TX_RDY_R(rdy_w[1]), .TXD(txd_w[1]), .TX_BUSY(busy_w[1]), .TX_DONE(done_w[1]));
   vs_uart_tx_buf #(.DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_c (
      .CLK(CLK), .RST(RST), .TX_RDY_T(vld_w[2]), .TX_DATA_R(tx_d),
      .TX_RDY_R(rdy_w[2]), .TXD(txd_w[2]), .TX_BUSY(busy_w[2]), .TX_DONE(done_w[2]));
   vs_uart_tx_buf u_d (
      .CLK(CLK), .RST(RST), .TX_RDY_T(vld_w[3]), .TX_DATA_R(tx_d),
      .TX_RDY_R(rdy_w[3]), .TXD(txd_w[3]), .TX_BUSY(busy_w[3]), .TX_DONE(done_w[3]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to #1 after edge kref+n (no-op if already there).
   task automatic at_edge(input int n);
      while (cyc < kref + n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b, output int k);
      int guard;
      tx_v  = 1'b1;
      tx_d  = b;
      guard = 0;
      while (!rdy_w[sel] && guard < 3000) begin
         @(posedge CLK);
         #1;
         guard++;
      end
      if (!rdy_w[sel]) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge CLK);
      #1;
      k    = cyc;
      tx_v = 1'b0;
   endtask

   task automatic capture(input int a, input int b);
      for (int n = a; n <= b; n++) begin
         at_edge(n);
         txd_s[n]  = txd_w[sel];
         busy_s[n] = busy_w[sel];
         done_s[n] = done_w[sel];
         rdy_s[n]  = rdy_w[sel];
      end
   endtask

   function automatic int cnt(input int which, input int a, input int b);
      int s = 0;
      for (int n = a; n <= b; n++) begin
         case (which)
            0:       s += int'(txd_s[n]);
            1:       s += int'(busy_s[n]);
            2:       s += int'(done_s[n]);
            default: s += int'(rdy_s[n]);
         endcase
      end
      return s;
   endfunction

   task automatic decode(input int st, input int nb, input int bl,
                         output logic [31:0] wd, output int gl);
      wd = '0;
      gl = 0;
      for (int b = 0; b < nb; b++) begin
         wd[b] = txd_s[st + b*bl + bl/2];
         for (int s = 0; s < bl; s++)
            if (txd_s[st + b*bl + s] !== txd_s[st + b*bl]) gl++;
      end
   endtask

   task automatic pulse_reset();
      RST = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b1;
   endtask

   initial begin
      RST  = 1'b0;
      tx_v = 1'b0;
      tx_d = 8'h00;
      sel  = 2'd0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_txd",  {28'd0, txd_w},  32'hF);
      chk("rst_rdy",  {28'd0, rdy_w},  32'hF);
      chk("rst_busy", {28'd0, busy_w}, 32'h0);
      chk("rst_done", {28'd0, done_w}, 32'h0);
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;

      // 8N1, single byte 0x55 from idle
      sel = 2'd0;
      send(8'h55, kref);
      chk("t1_rdy_low", {31'd0, rdy_w[0]}, 32'd0);
      capture(1, 700);
      chk("t1_txd_k1", {31'd0, txd_s[1]}, 32'd1);
      chk("t1_start_k2", {31'd0, txd_s[2]}, 32'd0);
      chk("t1_rdy_k1", {31'd0, rdy_s[1]}, 32'd1);
      decode(2, 10, 64, w, g);
      chk("t1_frame", w, 32'h2AA);
      chk("t1_bit_glitch", g, 0);
      chk("t1_busy_len", cnt(1, 1, 700), 640);
      chk("t1_done_cnt", cnt(2, 1, 700), 1);
      chk("t1_done_at", {31'd0, done_s[642]}, 32'd1);

      // back-to-back 0xA3, 0x0F
      send(8'hA3, kref);
      send(8'h0F, k2);
      chk("t2_second_accept", k2 - kref, 2);
      capture(2, 1350);
      decode(2, 20, 64, w, g);
      chk("t2_frames", w, 32'h87B46);
      chk("t2_bit_glitch", g, 0);
      chk("t2_rdy_held_low", cnt(3, 3, 640), 0);
      chk("t2_rdy_rise", {31'd0, rdy_s[641]}, 32'd1);
      chk("t2_busy_len", cnt(1, 2, 1350), 1280);
      chk("t2_done_cnt", cnt(2, 2, 1350), 2);
      chk("t2_done1", {31'd0, done_s[642]}, 32'd1);
      chk("t2_done2", {31'd0, done_s[1282]}, 32'd1);

      // writes while holding is full are ignored
      send(8'h3C, kref);
      send(8'hC3, k2);
      tx_v = 1'b1;
      tx_d = 8'hFF;
      capture(2, 600);
      tx_v = 1'b0;
      capture(601, 1350);
      chk("t5_rdy_low", cnt(3, 3, 600), 0);
      decode(2, 20, 64, w, g);
      chk("t5_frames", w, 32'hE1A78);
      chk("t5_idle_txd", {31'd0, txd_s[1340]}, 32'd1);
      chk("t5_idle_busy", {31'd0, busy_s[1340]}, 32'd0);

      // even parity, 2 stop bits
      sel = 2'd1;
      send(8'h07, kref);
      capture(1, 800);
      decode(2, 12, 64, w, g);
      chk("t3e_frame", w, 32'hE0E);
      chk("t3e_bit_glitch", g, 0);
      chk("t3e_busy_len", cnt(1, 1, 800), 768);
      chk("t3e_done_at", {31'd0, done_s[770]}, 32'd1);

      // odd parity, 2 stop bits
      sel = 2'd2;
      send(8'h07, kref);
      capture(1, 800);
      decode(2, 12, 64, w, g);
      chk("t3o_frame", w, 32'hC0E);
      chk("t3o_busy_len", cnt(1, 1, 800), 768);

      // reset during data bit 3 with a byte pending
      sel = 2'd0;
      send(8'h52, kref);
      send(8'h99, k2);
      at_edge(289);
      chk("t4_pre_txd", {31'd0, txd_w[0]}, 32'd0);
      chk("t4_pre_rdy", {31'd0, rdy_w[0]}, 32'd0);
      pulse_reset();
      chk("t4_txd",  {31'd0, txd_w[0]},  32'd1);
      chk("t4_rdy",  {31'd0, rdy_w[0]},  32'd1);
      chk("t4_busy", {31'd0, busy_w[0]}, 32'd0);
      chk("t4_done", {31'd0, done_w[0]}, 32'd0);
      kref = cyc;
      capture(1, 1400);
      chk("t4_line_idle", cnt(0, 1, 1400), 1400);
      chk("t4_no_busy", cnt(1, 1, 1400), 0);
      chk("t4_no_done", cnt(2, 1, 1400), 0);

      // default divider: 13888 clocks per bit
      sel = 2'd3;
      send(8'h00, kref);
      at_edge(1);
      chk("t6_txd_k1", {31'd0, txd_w[3]}, 32'd1);
      at_edge(2);
      chk("t6_start", {31'd0, txd_w[3]}, 32'd0);
      at_edge(27777);
      chk("t6_low_2bits", {31'd0, txd_w[3]}, 32'd0);
      chk("t6_busy", {31'd0, busy_w[3]}, 32'd1);
      pulse_reset();
      chk("t6_abort_txd", {31'd0, txd_w[3]}, 32'd1);
      send(8'h02, kref);
      at_edge(27777);
      chk("t6_bit0_end", {31'd0, txd_w[3]}, 32'd0);
      at_edge(27778);
      chk("t6_bit1_start", {31'd0, txd_w[3]}, 32'd1);
      pulse_reset();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
